// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling.
//
// The asynchronous rx line is brought into the clk domain by a two-flop
// synchronizer. A free-running divider produces one tick per 1/16 bit
// period. A small FSM finds the start bit, samples it at mid-bit, samples
// each data bit 16 ticks later, and checks the stop bit. A good frame
// updates data_out and raises data_ready_pulse for one cycle. A low stop
// bit raises frame_error for one cycle and then waits for the line to
// return high, so a held break reports one error and no phantom bytes.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   asynchronous, active-high
//   rx               in   serial line, idles high
//   data_out         out  [7:0] last correctly framed byte (LSB first on line)
//   data_ready_pulse out  one-cycle strobe when data_out updates
//   frame_error      out  one-cycle strobe when the stop bit is sampled low
//   busy             out  high whenever the FSM is not idle
//
// Handshake: there is no backpressure. data_ready_pulse is a single-cycle
// valid with an implied always-ready sink; data_out is valid on that cycle
// and holds until the next good frame.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_ready_pulse,
  output logic       frame_error,
  output logic       busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // Synchronizer: both stages reset to the idle (high) level.
  logic rx_m, rx_s;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Oversampling tick: free-running, not re-phased on start detection,
  // so the first sample point can jitter by up to one tick.
  logic [CW-1:0] cnt;
  logic          tick;
  assign tick = (cnt == DIV_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  state_t      state, state_n;
  logic [3:0]  s, s_n;
  logic [2:0]  n, n_n;
  logic [7:0]  sh, sh_n;
  logic [7:0]  dout_n;
  logic        rdy_n, ferr_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      s                <= '0;
      n                <= '0;
      sh               <= '0;
      data_out         <= '0;
      data_ready_pulse <= 1'b0;
      frame_error      <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      s                <= s_n;
      n                <= n_n;
      sh               <= sh_n;
      data_out         <= dout_n;
      data_ready_pulse <= rdy_n;
      frame_error      <= ferr_n;
      busy             <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    sh_n    = sh;
    dout_n  = data_out;
    rdy_n   = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == 4'd7) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state_n = IDLE;
            end
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == 4'd15) begin
            sh_n = {rx_s, sh[7:1]};
            s_n  = '0;
            if (n == 3'd7) state_n = STOP;
            else n_n = n + 3'd1;
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == 4'd15) begin
            s_n = '0;
            if (rx_s) begin
              dout_n  = sh;
              rdy_n   = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = WAIT_IDLE;
            end
          end else begin
            s_n = s + 4'd1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT_CLKS = 160;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_ready_pulse;
  logic       frame_error;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  int ferr_cnt = 0;
  int cyc = 0;
  int t_last = 0;
  int t_prev = 0;
  logic prev_rdy = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ(1_600_000),
    .BAUD_RATE(10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data_out(data_out),
    .data_ready_pulse(data_ready_pulse),
    .frame_error(frame_error),
    .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: pops one expected byte per data_ready_pulse.
  always @(negedge clk) begin
    if (reset) begin
      prev_rdy  = 1'b0;
      prev_ferr = 1'b0;
    end else begin
      if (data_ready_pulse) begin
        rdy_cnt++;
        t_prev = t_last;
        t_last = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got byte %02h, required no pulse", data_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data_out !== e) begin
            n_err++;
            $display("FAIL sb_data: got %02h, required %02h", data_out, e);
          end
        end
      end
      if (frame_error) ferr_cnt++;
      if (data_ready_pulse || frame_error) begin
        n_cmp++;
        if ((data_ready_pulse && frame_error) || (data_ready_pulse && prev_rdy) ||
            (frame_error && prev_ferr)) begin
          n_err++;
          $display("FAIL strobe_rule: rdy=%0b ferr=%0b prev_rdy=%0b prev_ferr=%0b, required single exclusive strobes",
                   data_ready_pulse, frame_error, prev_rdy, prev_ferr);
        end
      end
      prev_rdy  = data_ready_pulse;
      prev_ferr = frame_error;
    end
  end

  // Driver tasks
  task automatic send_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int clks);
    send_bit(1'b0, clks);
    for (int i = 0; i < 8; i++) send_bit(d[i], clks);
    send_bit(stop, clks);
  endtask

  task automatic idle(input int clks);
    send_bit(1'b1, clks);
  endtask

  // Tests
  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (data_out !== 8'h00 || data_ready_pulse !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got data=%02h rdy=%0b ferr=%0b busy=%0b, required 00/0/0/0",
               data_out, data_ready_pulse, frame_error, busy);
    end
    reset = 1'b0;
    idle(2 * BIT_CLKS);
  endtask

  task automatic test_single;
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hCD);
    send_frame(8'hCD, 1'b1, BIT_CLKS);
    idle(2 * BIT_CLKS);
    n_cmp++;
    if (rdy_cnt - r0 !== 1) begin
      n_err++;
      $display("FAIL single_pulses: got %0d, required 1", rdy_cnt - r0);
    end
    n_cmp++;
    if (ferr_cnt - f0 !== 0) begin
      n_err++;
      $display("FAIL single_ferr: got %0d, required 0", ferr_cnt - f0);
    end
    n_cmp++;
    if (data_out !== 8'hCD) begin
      n_err++;
      $display("FAIL single_data: got %02h, required cd", data_out);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy: got %0b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = rdy_cnt;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 1'b1, BIT_CLKS);
    send_frame(8'hAA, 1'b1, BIT_CLKS);
    idle(2 * BIT_CLKS);
    n_cmp++;
    if (rdy_cnt - r0 !== 2) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d, required 2", rdy_cnt - r0);
    end
    n_cmp++;
    if ((t_last - t_prev) < 1588 || (t_last - t_prev) > 1612) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d clocks, required 1600 +/- 12", t_last - t_prev);
    end
    n_cmp++;
    if (data_out !== 8'hAA) begin
      n_err++;
      $display("FAIL b2b_data: got %02h, required aa", data_out);
    end
  endtask

  task automatic test_glitch;
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_bit(1'b0, 10);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_busy_high: got %0b, required 1", busy);
    end
    send_bit(1'b0, 30);
    idle(100);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_busy_low: got %0b, required 0", busy);
    end
    idle(2 * BIT_CLKS);
    n_cmp++;
    if (rdy_cnt - r0 !== 0 || ferr_cnt - f0 !== 0) begin
      n_err++;
      $display("FAIL glitch_strobes: got rdy=%0d ferr=%0d, required 0/0", rdy_cnt - r0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_error;
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'h12, 1'b0, BIT_CLKS);
    send_bit(1'b0, 20 * BIT_CLKS);
    n_cmp++;
    if (ferr_cnt - f0 !== 1) begin
      n_err++;
      $display("FAIL ferr_count: got %0d, required 1", ferr_cnt - f0);
    end
    n_cmp++;
    if (rdy_cnt - r0 !== 0) begin
      n_err++;
      $display("FAIL ferr_no_pulse: got %0d, required 0", rdy_cnt - r0);
    end
    n_cmp++;
    if (data_out !== 8'hAA) begin
      n_err++;
      $display("FAIL ferr_data_hold: got %02h, required aa", data_out);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL ferr_break_busy: got %0b, required 1", busy);
    end
    idle(2 * BIT_CLKS);
    r0 = rdy_cnt;
    exp_q.push_back(8'hD1);
    send_frame(8'hD1, 1'b1, BIT_CLKS);
    idle(2 * BIT_CLKS);
    n_cmp++;
    if (rdy_cnt - r0 !== 1 || data_out !== 8'hD1) begin
      n_err++;
      $display("FAIL ferr_recover: got pulses=%0d data=%02h, required 1/d1", rdy_cnt - r0, data_out);
    end
  endtask

  task automatic test_reset_mid;
    int r0;
    logic [7:0] d;
    d = 8'h7E;
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) send_bit(d[i], BIT_CLKS);
    send_bit(d[3], BIT_CLKS / 2);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (data_out !== 8'h00 || data_ready_pulse !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got data=%02h rdy=%0b ferr=%0b busy=%0b, required 00/0/0/0",
               data_out, data_ready_pulse, frame_error, busy);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(20 * BIT_CLKS);
    r0 = rdy_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    idle(2 * BIT_CLKS);
    n_cmp++;
    if (rdy_cnt - r0 !== 1 || data_out !== 8'h3C) begin
      n_err++;
      $display("FAIL midreset_recover: got pulses=%0d data=%02h, required 1/3c", rdy_cnt - r0, data_out);
    end
  endtask

  task automatic test_baud_skew;
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 165);
    idle(2 * BIT_CLKS);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 155);
    idle(2 * BIT_CLKS);
    n_cmp++;
    if (rdy_cnt - r0 !== 2 || ferr_cnt - f0 !== 0) begin
      n_err++;
      $display("FAIL skew_counts: got rdy=%0d ferr=%0d, required 2/0", rdy_cnt - r0, ferr_cnt - f0);
    end
    n_cmp++;
    if (data_out !== 8'hA5) begin
      n_err++;
      $display("FAIL skew_data: got %02h, required a5", data_out);
    end
  endtask

  task automatic test_random_bytes;
    logic [7:0] d;
    int r0;
    r0 = rdy_cnt;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, 1'b1, BIT_CLKS);
      idle($urandom_range(0, 40));
    end
    idle(2 * BIT_CLKS);
    n_cmp++;
    if (rdy_cnt - r0 !== 4) begin
      n_err++;
      $display("FAIL random_pulses: got %0d, required 4", rdy_cnt - r0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_reset_mid;
    test_baud_skew;
    test_random_bytes;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending bytes, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
